// File: rtl/bin2bcd16_seq.sv
// Sequential 16-bit binary-to-BCD converter: one double-dabble step per clock
// under a start/ready/done handshake, presenting five registered BCD digits.
module bin2bcd16_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [15:0] inBin,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [3:0] thousands10,
   output logic [3:0] thousands,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state;
   logic [15:0] bin_reg;
   logic [19:0] scratch;
   logic [3:0]  bit_cnt;
   logic [19:0] result;
   logic [19:0] corrected;
   logic [19:0] next_scratch;
   logic [3:0]  digit;

   // Add-3 correction on every digit in parallel, then the shift that pulls
   // the next binary bit into the scratch LSB.
   always_comb begin
      corrected = '0;
      digit     = '0;
      for (int i = 0; i < 5; i++) begin
         digit = scratch[4*i +: 4];
         corrected[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
      end
      next_scratch = {corrected[18:0], bin_reg[15]};
   end

   // Result is only written on the final shift, so the digit outputs never
   // expose a partially converted value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         bin_reg <= '0;
         scratch <= '0;
         bit_cnt <= '0;
         result  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bin_reg <= inBin;
                  scratch <= '0;
                  bit_cnt <= '0;
                  state   <= ST_CONV;
               end
            end
            ST_CONV: begin
               scratch <= next_scratch;
               bin_reg <= {bin_reg[14:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) begin
                  result <= next_scratch;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready       = (state == ST_IDLE);
   assign busy        = (state == ST_CONV) || (state == ST_DONE);
   assign done        = (state == ST_DONE);
   assign thousands10 = result[19:16];
   assign thousands   = result[15:12];
   assign hundreds    = result[11:8];
   assign tens        = result[7:4];
   assign ones        = result[3:0];

endmodule
